// File: rtl/filter3x3_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : filter3x3_window_ctrl
//  Purpose  : Sequencing controller for the 3x3 filter datapath. Accepts a
//             raster pixel stream (valid/ready/sop/eop), drives the shift
//             enable of the window registers and line buffers, tracks the
//             row/column of the pixel being accepted and emits one handshaked
//             "window valid" beat per interior pixel.
//  Ports    : clk, reset_n          - clock, async active-low reset
//             in_valid/in_sop/in_eop/in_ready - upstream pixel handshake
//             shift_en             - window/line-buffer shift strobe
//             col, row             - position of the pixel presented
//             out_valid/out_ready/out_sop/out_eop - window beat handshake
//             busy                 - frame in progress
//             err_frame            - one-cycle framing error pulse
//  Revision : 1.0 - initial release
// ============================================================================
module filter3x3_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    output logic             shift_en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic             busy,
    output logic             err_frame
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_WIN_COL  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_WIN_ROW  = ROW_W'(2);

    logic [0:0]       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_out_valid;
    logic             r_out_sop;
    logic             r_out_eop;
    logic             r_err;

    logic w_accept;
    logic w_start;
    logic w_cont;
    logic w_last;
    logic w_early_eop;
    logic w_last_acc;
    logic w_beat;
    logic w_err;

    // A stalled window beat blocks the input so no pixel shifts under it.
    assign in_ready = reset_n & ~(r_out_valid & ~out_ready);
    assign w_accept = in_valid & in_ready;

    // sop always (re)starts a frame at (0,0), also when eop is set with it.
    assign w_start     = w_accept & in_sop;
    assign w_cont      = w_accept & ~in_sop & (r_state == c_ST_ACTIVE);
    assign w_last      = (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);
    assign w_early_eop = w_cont & in_eop & ~w_last;
    assign w_last_acc  = w_cont & w_last;

    // Accepting (r,c) completes the window centred on (r-1,c-1).
    assign w_beat = w_cont & ~w_early_eop & (r_row >= c_WIN_ROW) & (r_col >= c_WIN_COL);

    assign w_err = (w_start & (r_state == c_ST_ACTIVE))
                 | w_early_eop
                 | (w_last_acc & ~in_eop);

    // Frame state and position counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_start) begin
            r_state <= c_ST_ACTIVE;
            r_col   <= COL_W'(1);
            r_row   <= '0;
        end else if (w_early_eop || w_last_acc) begin
            r_state <= c_ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_cont) begin
            if (r_col == c_LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Window beat register: a new completing pixel can only be accepted when
    // the slot is empty or being drained this cycle, so loading wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else if (w_beat) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= (r_row == c_WIN_ROW) && (r_col == c_WIN_COL);
            r_out_eop   <= w_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    assign shift_en  = w_start | w_cont;
    assign col       = r_col;
    assign row       = r_row;
    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign busy      = (r_state == c_ST_ACTIVE);
    assign err_frame = r_err;

endmodule
`default_nettype wire

// File: tb/tb_filter3x3_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_filter3x3_window_ctrl
//  Purpose  : Self-checking bench for filter3x3_window_ctrl on a 5x4 image,
//             compared cycle by cycle against a position-based frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_filter3x3_window_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = 3;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          busy;
    logic          err_frame;

    filter3x3_window_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_ready (in_ready),
        .shift_en (shift_en),
        .col      (col),
        .row      (row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .busy     (busy),
        .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: frame position and outstanding beat
    bit m_active, m_pending, m_psop, m_peop, m_err;
    int m_r, m_c;

    // Observed activity counters per test
    int o_shift, o_beats, o_err, o_first_sop, o_last_eop;

    int ready_mode;   // 0: always ready, 1: toggle, 2: random
    bit ready_tog;
    int valid_pct;

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_psop = 0; m_peop = 0; m_err = 0;
        m_r = 0; m_c = 0;
    endtask

    task automatic clear_counts();
        o_shift = 0; o_beats = 0; o_err = 0; o_first_sop = 0; o_last_eop = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic v, input logic s, input logic e, output bit acc);
        logic ordy;
        bit   shift, beat, bsop, beop, err, last;
        int   pr, pc;
        shift = 0; beat = 0; bsop = 0; beop = 0; err = 0; last = 0; pr = 0; pc = 0;
        case (ready_mode)
            0:       ordy = 1'b1;
            1:       begin ordy = ready_tog; ready_tog = !ready_tog; end
            default: ordy = 1'($urandom_range(0, 1));
        endcase
        in_valid = v; in_sop = s; in_eop = e; out_ready = ordy;
        #1;
        checks++;
        if (out_valid !== m_pending) begin
            failures++; $display("FAIL out_valid: got %b expected %b", out_valid, m_pending);
        end
        if (m_pending) begin
            checks++;
            if ({out_sop, out_eop} !== {m_psop, m_peop}) begin
                failures++;
                $display("FAIL beat_flags: got sop=%b eop=%b expected sop=%b eop=%b",
                         out_sop, out_eop, m_psop, m_peop);
            end
        end
        checks++;
        if (err_frame !== m_err) begin
            failures++; $display("FAIL err_frame: got %b expected %b", err_frame, m_err);
        end
        checks++;
        if (busy !== m_active) begin
            failures++; $display("FAIL busy: got %b expected %b", busy, m_active);
        end
        checks++;
        if ({col, row} !== {CW'(m_c), RW'(m_r)}) begin
            failures++; $display("FAIL position: got col=%0d row=%0d expected col=%0d row=%0d",
                                 col, row, m_c, m_r);
        end
        checks++;
        if (in_ready !== !(m_pending && !ordy)) begin
            failures++; $display("FAIL in_ready: got %b expected %b", in_ready, !(m_pending && !ordy));
        end
        acc = v && !(m_pending && !ordy);
        if (acc) begin
            if (s) begin
                shift = 1; err = m_active; pr = 0; pc = 0;
            end else if (m_active) begin
                shift = 1; pr = m_r; pc = m_c;
            end
            if (shift) begin
                last = (pr == H - 1) && (pc == W - 1);
                if (e && !s && !last) begin
                    err = 1; m_active = 0; m_r = 0; m_c = 0;
                end else begin
                    if (pr >= 2 && pc >= 2) begin
                        beat = 1; bsop = (pr == 2) && (pc == 2); beop = last;
                    end
                    if (last) begin
                        if (!e) err = 1;
                        m_active = 0; m_r = 0; m_c = 0;
                    end else begin
                        m_active = 1; m_r = pr; m_c = pc + 1;
                        if (m_c == W) begin m_c = 0; m_r = m_r + 1; end
                    end
                end
            end
        end
        checks++;
        if (shift_en !== shift) begin
            failures++; $display("FAIL shift_en: got %b expected %b", shift_en, shift);
        end
        if (shift_en === 1'b1) o_shift++;
        if (err_frame === 1'b1) o_err++;
        if (out_valid === 1'b1 && ordy) begin
            o_beats++;
            if (o_beats == 1) o_first_sop = int'(out_sop);
            o_last_eop = int'(out_eop);
        end
        if (beat) begin
            m_pending = 1; m_psop = bsop; m_peop = beop;
        end else if (m_pending && ordy) begin
            m_pending = 0; m_psop = 0; m_peop = 0;
        end
        m_err = err;
        @(negedge clk);
    endtask

    // Present one pixel until it is accepted, with random idle gaps.
    task automatic send_pix(input logic s, input logic e);
        bit acc;
        int n;
        n = 0; acc = 0;
        while (!acc && n < 100) begin
            if ($urandom_range(0, 99) >= valid_pct)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            else
                step(1'b1, s, e, acc);
            n++;
        end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, acc);
    endtask

    // Pixels idx_from..idx_to (raster index) of a well-formed frame.
    task automatic send_range(input int idx_from, input int idx_to);
        for (int i = idx_from; i <= idx_to; i++)
            send_pix(i == 0, i == W * H - 1);
    endtask

    task automatic check_counts(input string tag, input int shifts, input int beats, input int errs);
        checks++;
        if (o_shift !== shifts) begin
            failures++; $display("FAIL %s shift_count: got %0d expected %0d", tag, o_shift, shifts);
        end
        checks++;
        if (o_beats !== beats) begin
            failures++; $display("FAIL %s beat_count: got %0d expected %0d", tag, o_beats, beats);
        end
        checks++;
        if (o_err !== errs) begin
            failures++; $display("FAIL %s err_count: got %0d expected %0d", tag, o_err, errs);
        end
        if (beats > 0) begin
            checks++;
            if (o_first_sop !== 1 || o_last_eop !== 1) begin
                failures++;
                $display("FAIL %s sop_eop: got first_sop=%0d last_eop=%0d expected 1 1",
                         tag, o_first_sop, o_last_eop);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0; in_valid = 1; in_sop = 1; in_eop = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, shift_en, out_valid, out_sop, out_eop, busy, err_frame} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {in_ready, shift_en, out_valid, out_sop, out_eop, busy, err_frame});
        end
        checks++;
        if ({col, row} !== 5'b0) begin
            failures++; $display("FAIL reset_position: got col=%0d row=%0d expected 0 0", col, row);
        end
        reset_n = 1; in_valid = 0; in_sop = 0;
        model_reset();
    endtask

    task automatic test_normal_frame();
        ready_mode = 0; valid_pct = 100; clear_counts();
        send_range(0, W * H - 1);
        idle(3);
        check_counts("normal", 20, 6, 0);
    endtask

    task automatic test_stall();
        ready_mode = 1; ready_tog = 1; valid_pct = 100; clear_counts();
        send_range(0, W * H - 1);
        idle(4);
        check_counts("stall", 20, 6, 0);
    endtask

    task automatic test_drop();
        ready_mode = 0; valid_pct = 100; clear_counts();
        send_pix(1'b0, 1'b0);
        send_pix(1'b0, 1'b1);
        send_pix(1'b0, 1'b0);
        idle(2);
        check_counts("drop", 0, 0, 0);
        clear_counts();
        send_range(0, W * H - 1);
        idle(3);
        check_counts("after_drop", 20, 6, 0);
    endtask

    task automatic test_restart_sop();
        ready_mode = 2; valid_pct = 80; clear_counts();
        send_range(0, 2 * W + 2);      // up to (2,2): one beat
        send_pix(1'b1, 1'b0);          // sop at (2,3) restarts the frame
        send_range(1, W * H - 1);
        idle(4);
        check_counts("restart", 13 + 20, 7, 1);
    endtask

    task automatic test_eop_errors();
        ready_mode = 0; valid_pct = 100; clear_counts();
        send_range(0, 2 * W);          // through (2,0)
        send_pix(1'b0, 1'b1);          // premature eop at (2,1)
        send_pix(1'b0, 1'b0);          // IDLE, dropped
        idle(2);
        check_counts("early_eop", 12, 0, 1);
        clear_counts();
        send_range(0, W * H - 2);
        send_pix(1'b0, 1'b0);          // last pixel without eop
        idle(3);
        check_counts("missing_eop", 20, 6, 1);
    endtask

    task automatic test_reset_mid();
        ready_mode = 0; valid_pct = 100; clear_counts();
        send_range(0, 2 * W + 2);      // beat from (2,2) now pending
        in_valid = 1; in_sop = 0; in_eop = 0; out_ready = 0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++; $display("FAIL stall_before_reset: got valid/ready=%b expected 10", {out_valid, in_ready});
        end
        reset_n = 0;
        #1;
        checks++;
        if ({in_ready, shift_en, out_valid, out_sop, out_eop, busy, err_frame, col, row} !== 12'b0) begin
            failures++;
            $display("FAIL async_reset: got %b expected all zero",
                     {in_ready, shift_en, out_valid, out_sop, out_eop, busy, err_frame, col, row});
        end
        model_reset();
        @(negedge clk);
        reset_n = 1; in_valid = 0;
        ready_mode = 2; valid_pct = 70; clear_counts();
        send_range(0, W * H - 1);
        idle(6);
        check_counts("after_reset", 20, 6, 0);
    endtask

    task automatic test_random();
        int idx;
        logic s, e;
        ready_mode = 2; valid_pct = 75; idx = 0;
        for (int k = 0; k < 300; k++) begin
            s = (idx == 0) || ($urandom_range(0, 99) < 3);
            e = (idx == W * H - 1) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 3);
            send_pix(s, e);
            idx = (idx + 1) % (W * H);
        end
        idle(6);
    endtask

    initial begin
        model_reset(); clear_counts();
        ready_mode = 0; ready_tog = 0; valid_pct = 100;
        test_reset();
        test_normal_frame();
        test_stall();
        test_drop();
        test_restart_sop();
        test_eop_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
